// File: rtl/cube_sum_pipe.sv
// cube_sum_pipe: streaming sum-of-cubes over in_last-delimited frames, one {sum,count,ovf} record per frame.
// Build option CUBE_SUM_SAT_EN: sum/count saturate at all-ones instead of wrapping (ovf flags either way).
module cube_sum_pipe #(
   parameter int unsigned ACC_W = 40,
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [7:0]       in_data,
   input  logic             in_last,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [ACC_W-1:0] out_sum,
   output logic [CNT_W-1:0] out_count,
   output logic             out_ovf
);

   localparam int unsigned X_W    = 8;
   localparam int unsigned SQ_W   = 2 * X_W;
   localparam int unsigned CUBE_W = 3 * X_W;   // 255^3 < 2^24, so the cube never needs more
   localparam int unsigned ACC_XW = ACC_W + 1;
   localparam int unsigned CNT_XW = CNT_W + 1;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_HOLD = 1'b1
   } state_t;

   state_t              r_state;
   state_t              w_state_nxt;

   logic [X_W-1:0]      r_s1_x;
   logic                r_s1_last;
   logic                r_s1_v;
   logic [CUBE_W-1:0]   r_s2_cube;
   logic                r_s2_last;
   logic                r_s2_v;

   logic [ACC_W-1:0]    r_acc;
   logic [CNT_W-1:0]    r_cnt;
   logic                r_ovf;

   logic                w_stall;
   logic                w_xfer;
   logic                w_acc_fire;
   logic                w_close;
   logic [SQ_W-1:0]     w_sq;
   logic [CUBE_W-1:0]   w_cube;
   logic [ACC_XW-1:0]   w_acc_add;
   logic [CNT_XW-1:0]   w_cnt_add;
   logic [ACC_W-1:0]    w_acc_nxt;
   logic [CNT_W-1:0]    w_cnt_nxt;
   logic                w_ovf_nxt;

   // Handshake: everything freezes while a finished record waits for the consumer
   assign w_stall    = out_valid & ~out_ready;
   assign in_ready   = ~w_stall & ~rst;
   assign w_xfer     = in_valid & in_ready;
   assign w_acc_fire = r_s2_v & ~w_stall;
   assign w_close    = w_acc_fire & r_s2_last;

   assign w_sq   = SQ_W'(r_s1_x) * SQ_W'(r_s1_x);
   assign w_cube = CUBE_W'(w_sq) * CUBE_W'(r_s1_x);

   assign w_acc_add = ACC_XW'(r_acc) + ACC_XW'(r_s2_cube);
   assign w_cnt_add = CNT_XW'(r_cnt) + CNT_XW'(1);

`ifdef CUBE_SUM_SAT_EN
   assign w_acc_nxt = w_acc_add[ACC_W] ? {ACC_W{1'b1}} : w_acc_add[ACC_W-1:0];
   assign w_cnt_nxt = w_cnt_add[CNT_W] ? {CNT_W{1'b1}} : w_cnt_add[CNT_W-1:0];
`else
   assign w_acc_nxt = w_acc_add[ACC_W-1:0];
   assign w_cnt_nxt = w_cnt_add[CNT_W-1:0];
`endif

   assign w_ovf_nxt = r_ovf | w_acc_add[ACC_W] | w_cnt_add[CNT_W];

   // S1 operand register and S2 cube register
   always_ff @(posedge clk) begin
      if (rst) begin
         r_s1_x    <= '0;
         r_s1_last <= 1'b0;
         r_s1_v    <= 1'b0;
         r_s2_cube <= '0;
         r_s2_last <= 1'b0;
         r_s2_v    <= 1'b0;
      end else if (!w_stall) begin
         r_s1_x    <= in_data;
         r_s1_last <= in_last;
         r_s1_v    <= w_xfer;
         r_s2_cube <= w_cube;
         r_s2_last <= r_s1_last;
         r_s2_v    <= r_s1_v;
      end
   end

   // Frame accumulator; restarts from zero once a frame closes
   always_ff @(posedge clk) begin
      if (rst) begin
         r_acc <= '0;
         r_cnt <= '0;
         r_ovf <= 1'b0;
      end else if (w_acc_fire) begin
         if (r_s2_last) begin
            r_acc <= '0;
            r_cnt <= '0;
            r_ovf <= 1'b0;
         end else begin
            r_acc <= w_acc_nxt;
            r_cnt <= w_cnt_nxt;
            r_ovf <= w_ovf_nxt;
         end
      end
   end

   // Output record, stable until the next close
   always_ff @(posedge clk) begin
      if (rst) begin
         out_sum   <= '0;
         out_count <= '0;
         out_ovf   <= 1'b0;
      end else if (w_close) begin
         out_sum   <= w_acc_nxt;
         out_count <= w_cnt_nxt;
         out_ovf   <= w_ovf_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // A close in HOLD can only happen with out_ready=1, so HOLD simply persists
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: if (w_close) w_state_nxt = ST_HOLD;
         ST_HOLD: if (out_ready && !w_close) w_state_nxt = ST_IDLE;
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      out_valid = 1'b0;
      if (r_state == ST_HOLD) out_valid = 1'b1;
   end

endmodule
